// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin FIFO drain arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BURST      = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    OUTPUT
  } arb_state_e;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above start, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_CH = DEF_NUM_CH,
  localparam int unsigned IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  start_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned       k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return IDX_W'(s);
  endfunction

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!found_o && req_i[wrap_add(start_i, k)]) begin
        found_o = 1'b1;
        idx_o   = wrap_add(start_i, k);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arb.sv
// Drains NUM_CH FIFO read ports round-robin, up to BURST words per grant,
// into a single registered valid/ready output stream.
module fifo_rr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_CH     = DEF_NUM_CH,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned BURST      = DEF_BURST,
  localparam int unsigned IDX_W      = idx_width(NUM_CH),
  localparam int unsigned CNT_W      = $clog2(BURST) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
  output logic [NUM_CH-1:0]            ch_ren,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]             out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]       burst_q, burst_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]       out_ch_q, out_ch_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [DATA_WIDTH-1:0]  dout_sel;
  logic [IDX_W-1:0]       next_ptr;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req_i   (~ch_empty),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    dout_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch_q == IDX_W'(i)) dout_sel = ch_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign next_ptr = (cur_ch_q == IDX_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;

  // Read strobe is decoded from the state register so reset kills it immediately.
  always_comb begin
    ch_ren = '0;
    if (state_q == READ && !ch_empty[cur_ch_q]) ch_ren[cur_ch_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_ch_d   = cur_ch_q;
    burst_d    = burst_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          cur_ch_d = pick_idx;
          state_d  = READ;
        end
      end
      READ: begin
        if (ch_empty[cur_ch_q]) begin
          burst_d = '0;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_data_d = dout_sel;
        out_ch_d   = cur_ch_q;
        state_d    = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          if (burst_q == CNT_W'(BURST - 1) || ch_empty[cur_ch_q]) begin
            rr_ptr_d = next_ptr;
            burst_d  = '0;
            state_d  = IDLE;
          end else begin
            burst_d = burst_q + 1'b1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_ch_q    <= '0;
      burst_q     <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      burst_q     <= burst_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
